// File: rtl/mic1_ctrl_pkg.sv
// Shared types for the MIC-1 execution controller and the front-panel FSM:
// controller state encoding and the LED bit positions both blocks agree on.
package mic1_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    STEP,
    HALT,
    RST
  } run_state_t;

  localparam int LED_RUN   = 0;
  localparam int LED_HALT  = 1;
  localparam int LED_IDLE  = 2;
  localparam int LED_STEP  = 3;
  localparam int LED_RST   = 4;
  localparam int LED_DRAIN = 5;

  // DRAIN is still executing, so it lights the RUN LED as well as its own.
  function automatic logic [5:0] ledFor(input run_state_t s);
    logic [5:0] l;
    l = '0;
    case (s)
      IDLE:    l[LED_IDLE] = 1'b1;
      RUN:     l[LED_RUN] = 1'b1;
      DRAIN: begin
        l[LED_RUN]   = 1'b1;
        l[LED_DRAIN] = 1'b1;
      end
      STEP:    l[LED_STEP] = 1'b1;
      HALT:    l[LED_HALT] = 1'b1;
      RST:     l[LED_RST] = 1'b1;
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic logic enFor(input run_state_t s);
    return (s == RUN) || (s == DRAIN) || (s == STEP);
  endfunction

endpackage

// File: rtl/mic1_run_ctrl.sv
// MIC-1 execution controller: turns panel command pulses into a datapath clock
// enable and reset pulse, halting only at macroinstruction boundaries.
module mic1_run_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 8,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             cmd_run,
  input  logic             cmd_stop,
  input  logic             cmd_step,
  input  logic             cmd_reset,
  input  logic             instr_boundary,
  output logic             cpu_en,
  output logic             cpu_sreset,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [5:0]       led
);

  localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_CYCLES - 1);

  run_state_t       state_q, state_d;
  logic [7:0]       pulseCnt_q, pulseCnt_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic             cpuEn_q, cpuSreset_q;
  logic [5:0]       led_q;

  // Reset outranks everything; within a state, stop > step > run.
  always_comb begin
    state_d    = state_q;
    pulseCnt_d = pulseCnt_q;
    cycleCnt_d = cycleCnt_q;
    if (cpuEn_q) begin
      cycleCnt_d = cycleCnt_q + CNT_W'(1);
    end
    if (cmd_reset) begin
      state_d    = RST;
      pulseCnt_d = PULSE_LOAD;
      cycleCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_step)     state_d = STEP;
          else if (cmd_run) state_d = RUN;
        end
        RUN: begin
          if (cmd_stop) state_d = instr_boundary ? HALT : DRAIN;
        end
        DRAIN, STEP: begin
          if (cmd_run)             state_d = RUN;
          else if (instr_boundary) state_d = HALT;
        end
        HALT: begin
          if (cmd_step)     state_d = STEP;
          else if (cmd_run) state_d = RUN;
        end
        RST: begin
          if (pulseCnt_q == 8'd0) state_d = IDLE;
          else                    pulseCnt_d = pulseCnt_q - 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      pulseCnt_q  <= '0;
      cycleCnt_q  <= '0;
      cpuEn_q     <= 1'b0;
      cpuSreset_q <= 1'b0;
      led_q       <= 6'b000100;
    end else begin
      state_q     <= state_d;
      pulseCnt_q  <= pulseCnt_d;
      cycleCnt_q  <= cycleCnt_d;
      cpuEn_q     <= enFor(state_d);
      cpuSreset_q <= (state_d == RST);
      led_q       <= ledFor(state_d);
    end
  end

  assign cpu_en     = cpuEn_q;
  assign cpu_sreset = cpuSreset_q;
  assign cycle_cnt  = cycleCnt_q;
  assign led        = led_q;

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Testbench for mic1_run_ctrl: directed scenarios plus random command traffic,
// checked every cycle against a behavioural model of the controller.
module tb_mic1_run_ctrl;

   localparam int PULSE = 8;

   logic clk = 1'b0;
   logic reset_;
   logic cmdRun, cmdStop, cmdStep, cmdReset, bnd;
   logic cpuEn, cpuSreset;
   logic [31:0] cycleCnt;
   logic [5:0] led;
   logic cpuEnN, cpuSresetN;
   logic [3:0] cycleCntN;
   logic [5:0] ledN;

   int checks = 0;
   int passes = 0;

   // Model: enabled / will-halt-at-boundary / step-vs-drain / has-run-before,
   // plus the number of reset-pulse cycles still to come and the enabled count.
   int rstLeft;
   bit mEn, mHaltAtBnd, mStepMode, mStarted;
   longint unsigned mCount;

   mic1_run_ctrl #(.RST_PULSE_CYCLES(PULSE), .CNT_W(32)) dut (
      .clk(clk), .reset_(reset_),
      .cmd_run(cmdRun), .cmd_stop(cmdStop), .cmd_step(cmdStep), .cmd_reset(cmdReset),
      .instr_boundary(bnd),
      .cpu_en(cpuEn), .cpu_sreset(cpuSreset), .cycle_cnt(cycleCnt), .led(led)
   );

   // A narrow counter instance shares the stimulus so wrap-around is exercised.
   mic1_run_ctrl #(.RST_PULSE_CYCLES(PULSE), .CNT_W(4)) dutNarrow (
      .clk(clk), .reset_(reset_),
      .cmd_run(cmdRun), .cmd_stop(cmdStop), .cmd_step(cmdStep), .cmd_reset(cmdReset),
      .instr_boundary(bnd),
      .cpu_en(cpuEnN), .cpu_sreset(cpuSresetN), .cycle_cnt(cycleCntN), .led(ledN)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input longint unsigned observed,
                              input longint unsigned expected);
      checks++;
      if (observed == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Expected LED pattern derived from the model's abstract status.
   function automatic logic [5:0] modelLed();
      logic [5:0] l;
      l = '0;
      if (rstLeft > 0) l[4] = 1'b1;
      else if (!mEn) begin
         if (mStarted) l[1] = 1'b1;
         else          l[2] = 1'b1;
      end else begin
         l[0] = !(mHaltAtBnd && mStepMode);
         l[3] = mHaltAtBnd && mStepMode;
         l[5] = mHaltAtBnd && !mStepMode;
      end
      return l;
   endfunction

   // Model response to the async reset.
   task automatic modelReset();
      rstLeft = 0;
      mEn = 0; mHaltAtBnd = 0; mStepMode = 0; mStarted = 0;
      mCount = 0;
   endtask

   // Model response to one clock edge with the given command pulses.
   task automatic modelStep(input bit run, input bit stop, input bit step,
                            input bit rst, input bit b);
      if (rst) begin
         rstLeft = PULSE;
         mEn = 0; mHaltAtBnd = 0; mStepMode = 0; mStarted = 0;
         mCount = 0;
      end else if (rstLeft > 0) begin
         rstLeft--;
      end else begin
         if (mEn) mCount++;
         if (mEn && !mHaltAtBnd) begin
            if (stop) begin
               if (b) begin mEn = 0; mStarted = 1; end
               else begin mHaltAtBnd = 1; mStepMode = 0; end
            end
         end else if (mEn) begin
            if (run) mHaltAtBnd = 0;
            else if (b) begin mEn = 0; mStarted = 1; end
         end else begin
            if (step) begin mEn = 1; mHaltAtBnd = 1; mStepMode = 1; end
            else if (run) begin mEn = 1; mHaltAtBnd = 0; end
         end
      end
   endtask

   // Compare every output of both instances against the model.
   task automatic checkState();
      checkOutput("cpu_en", cpuEn, mEn && rstLeft == 0);
      checkOutput("cpu_sreset", cpuSreset, rstLeft > 0);
      checkOutput("cycle_cnt", cycleCnt, mCount & 64'hFFFF_FFFF);
      checkOutput("led", led, modelLed());
      checkOutput("n_cpu_en", cpuEnN, mEn && rstLeft == 0);
      checkOutput("n_cpu_sreset", cpuSresetN, rstLeft > 0);
      checkOutput("n_cycle_cnt", cycleCntN, mCount % 16);
      checkOutput("n_led", ledN, modelLed());
   endtask

   // Drive one cycle of commands, clock it, then compare outputs.
   task automatic applyStimulus(input bit run, input bit stop, input bit step,
                                input bit rst, input bit b);
      cmdRun = run; cmdStop = stop; cmdStep = step; cmdReset = rst; bnd = b;
      @(posedge clk);
      modelStep(run, stop, step, rst, b);
      #1;
      cmdRun = 0; cmdStop = 0; cmdStep = 0; cmdReset = 0; bnd = 0;
      checkState();
   endtask

   // Directed scenarios first, then random traffic.
   initial begin
      int enSeen;
      int srCount;
      bit enDropped;
      cmdRun = 0; cmdStop = 0; cmdStep = 0; cmdReset = 0; bnd = 0;
      reset_ = 1'b0;
      modelReset();
      #12;
      checkOutput("rst_led", led, 6'b000100);
      checkOutput("rst_en", cpuEn, 0);
      checkOutput("rst_sreset", cpuSreset, 0);
      checkOutput("rst_cnt", cycleCnt, 0);
      reset_ = 1'b1;

      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("run_en", cpuEn, 1);
      for (int i = 1; i <= 10; i++) applyStimulus(0, 0, 0, 0, (i % 4) == 0);
      checkOutput("run_cnt10", cycleCnt, 10);
      checkOutput("run_led", led, 6'b000001);

      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("drain_led1", led, 6'b100001);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain_led2", led, 6'b100001);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("halt_led", led, 6'b000010);
      checkOutput("halt_en", cpuEn, 0);
      checkOutput("halt_cnt", cycleCnt, 13);

      applyStimulus(0, 0, 1, 0, 0);
      enSeen = int'(cpuEn);
      applyStimulus(0, 0, 0, 0, 0);
      enSeen += int'(cpuEn);
      applyStimulus(0, 0, 0, 0, 0);
      enSeen += int'(cpuEn);
      applyStimulus(0, 0, 0, 0, 1);
      enSeen += int'(cpuEn);
      checkOutput("step_en_cycles", enSeen, 3);
      checkOutput("step_cnt", cycleCnt, 16);
      checkOutput("step_led", led, 6'b000010);

      applyStimulus(1, 0, 0, 0, 0);
      for (int k = 0; k < 200 && mCount < 57; k++) applyStimulus(0, 0, 0, 0, (k % 5) == 4);
      checkOutput("pre_reset_cnt", cycleCnt, 57);
      applyStimulus(1, 0, 0, 1, 0);
      checkOutput("reset_cnt0", cycleCnt, 0);
      srCount = 0;
      for (int i = 0; i < 20; i++) begin
         srCount += int'(cpuSreset);
         applyStimulus(0, 0, 0, 0, 0);
      end
      checkOutput("sreset_cycles", srCount, PULSE);
      checkOutput("post_reset_led", led, 6'b000100);

      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      enDropped = !cpuEn;
      applyStimulus(1, 0, 0, 0, 0);
      enDropped |= !cpuEn;
      applyStimulus(0, 0, 0, 0, 0);
      enDropped |= !cpuEn;
      checkOutput("cancel_en_dropped", enDropped, 0);
      checkOutput("cancel_led", led, 6'b000001);

      applyStimulus(0, 0, 0, 1, 0);
      for (int i = 0; i < PULSE; i++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("narrow_wrap", cycleCntN, 1);
      checkOutput("wide_17", cycleCnt, 17);

      applyStimulus(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("mid_rst_sreset", cpuSreset, 1);
      reset_ = 1'b0;
      #2;
      modelReset();
      checkOutput("abort_sreset", cpuSreset, 0);
      checkOutput("abort_led", led, 6'b000100);
      checkState();
      @(posedge clk);
      #1;
      checkState();
      reset_ = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         int sel;
         sel = $urandom_range(0, 7);
         applyStimulus(sel == 0, sel == 1, sel == 2, $urandom_range(0, 63) == 0,
                       $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
